// File: rtl/array_multiplier_b0.sv
// array_multiplier_b0: unsigned 4x4 AND/ripple-adder array multiplier as a Tiny Tapeout tile.
// Operand A = ui_in[3:0], B = ui_in[7:4]; registered product on uo_out.
// Optional macro PIPE_STAGE_EN inserts a register after adder row 1 (latency 2 instead of 1).
module array_multiplier_b0 (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 2 * N;

  // One adder row: half adder on bit 0, full adders above; returns {carry, sum}.
  // prev is the previous row shifted right by one with its carry in the MSB.
  function automatic logic [N:0] add_row(input logic [N-1:0] pp, input logic [N-1:0] prev);
    logic         c;
    logic [N:0]   r;
    r    = '0;
    r[0] = pp[0] ^ prev[0];
    c    = pp[0] & prev[0];
    for (int j = 1; j < N; j++) begin
      r[j] = pp[j] ^ prev[j] ^ c;
      c    = (pp[j] & prev[j]) | (c & (pp[j] ^ prev[j]));
    end
    r[N] = c;
    return r;
  endfunction

  logic [N-1:0]  w_a;
  logic [N-1:0]  w_b;
  logic [N-1:0]  w_row0;
  logic [N:0]    w_row1;
  logic [N:0]    w_row1_s;
  logic [1:0]    w_p_lo;
  logic [1:0]    w_b_hi;
  logic [N-1:0]  w_a_s;
  logic [N:0]    w_row2;
  logic [N:0]    w_row3;
  logic [PW-1:0] w_prod;
  logic [PW-1:0] r_prod;
  logic          w_unused;

  assign w_a    = ui_in[3:0];
  assign w_b    = ui_in[7:4];
  assign w_row0 = w_a & {N{w_b[0]}};
  assign w_row1 = add_row(w_a & {N{w_b[1]}}, {1'b0, w_row0[N-1:1]});

`ifdef PIPE_STAGE_EN
  logic [N:0]   r_row1;
  logic [1:0]   r_p_lo;
  logic [1:0]   r_b_hi;
  logic [N-1:0] r_a;

  // Mid-array register: row-1 result, low product bits, and the operand bits rows 2-3 still need.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_row1 <= '0;
      r_p_lo <= '0;
      r_b_hi <= '0;
      r_a    <= '0;
    end else if (ena) begin
      r_row1 <= w_row1;
      r_p_lo <= {w_row1[0], w_row0[0]};
      r_b_hi <= w_b[3:2];
      r_a    <= w_a;
    end
  end

  assign w_row1_s = r_row1;
  assign w_p_lo   = r_p_lo;
  assign w_b_hi   = r_b_hi;
  assign w_a_s    = r_a;
`else
  assign w_row1_s = w_row1;
  assign w_p_lo   = {w_row1[0], w_row0[0]};
  assign w_b_hi   = w_b[3:2];
  assign w_a_s    = w_a;
`endif

  assign w_row2 = add_row(w_a_s & {N{w_b_hi[0]}}, w_row1_s[N:1]);
  assign w_row3 = add_row(w_a_s & {N{w_b_hi[1]}}, w_row2[N:1]);
  assign w_prod = {w_row3, w_row2[0], w_p_lo};

  // Output register: reset clears, ena loads, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod <= '0;
    end else if (ena) begin
      r_prod <= w_prod;
    end
  end

  assign uo_out   = r_prod;
  assign uio_out  = 8'h00;
  assign uio_oe   = 8'h00;
  assign w_unused = ^uio_in;

endmodule

// File: tb/tb_array_multiplier_b0.sv
// Self-checking bench for array_multiplier_b0; reference model is plain A*B through an L-deep pipe.
module tb_array_multiplier_b0;

`ifdef PIPE_STAGE_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_tests;
  int n_fail;

  logic [7:0] m0;
  logic [7:0] m1;

  array_multiplier_b0 dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] exp_out();
    return (L == 1) ? m0 : m1;
  endfunction

  // Drive inputs, take one clock edge, advance the model, then settle past the edge.
  task automatic step(input logic [7:0] ui, input logic r, input logic e);
    ui_in  = ui;
    rst    = r;
    ena    = e;
    uio_in = 8'($urandom);
    @(posedge clk);
    if (r) begin
      m0 = 8'h00;
      m1 = 8'h00;
    end else if (e) begin
      m1 = m0;
      m0 = 8'(ui[3:0]) * 8'(ui[7:4]);
    end
    #1;
  endtask

  task automatic test_reset();
    step(8'($urandom), 1'b1, 1'b1);
    step(8'($urandom), 1'b1, 1'b0);
    n_tests++;
    if (uo_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_uo_out: got %h expected 00", uo_out);
    end
    n_tests++;
    if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_uio: got oe=%h out=%h expected 00/00", uio_oe, uio_out);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ins  [3];
    logic [7:0] outs [3];
    ins[0] = 8'h53; outs[0] = 8'h0F;
    ins[1] = 8'hFF; outs[1] = 8'hE1;
    ins[2] = 8'hF0; outs[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < L; s++) step(ins[k], 1'b0, 1'b1);
      n_tests++;
      if (uo_out !== outs[k]) begin
        n_fail++;
        $display("FAIL directed_%h: got %h expected %h", ins[k], uo_out, outs[k]);
      end
    end
  endtask

  task automatic test_hold();
    for (int s = 0; s < L; s++) step(8'h77, 1'b0, 1'b1);
    n_tests++;
    if (uo_out !== 8'h31) begin
      n_fail++;
      $display("FAIL hold_load: got %h expected 31", uo_out);
    end
    for (int s = 0; s < 3; s++) begin
      step(8'h22, 1'b0, 1'b0);
      n_tests++;
      if (uo_out !== 8'h31) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got %h expected 31", s, uo_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq  [3];
    logic [7:0] want [3];
    logic [7:0] got  [3];
    seq[0] = 8'h53; want[0] = 8'h0F;
    seq[1] = 8'hFF; want[1] = 8'hE1;
    seq[2] = 8'h21; want[2] = 8'h02;
    for (int k = 0; k < 3 + L - 1; k++) begin
      step((k < 3) ? seq[k] : 8'h00, 1'b0, 1'b1);
      if (k >= L - 1) got[k-L+1] = uo_out;
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (got[k] !== want[k]) begin
        n_fail++;
        $display("FAIL stream_%0d: got %h expected %h", k, got[k], want[k]);
      end
    end
    step(8'hFF, 1'b1, 1'b1);
    n_tests++;
    if (uo_out !== 8'h00) begin
      n_fail++;
      $display("FAIL stream_reset: got %h expected 00", uo_out);
    end
  endtask

  task automatic test_exhaustive();
    for (int v = 0; v < 256 + L - 1; v++) begin
      step((v < 256) ? 8'(v) : 8'h00, 1'b0, 1'b1);
      if (v >= L - 1) begin
        n_tests++;
        if (uo_out !== exp_out()) begin
          n_fail++;
          $display("FAIL exhaustive_%02h: got %h expected %h", 8'(v - L + 1), uo_out, exp_out());
        end
      end
    end
  endtask

  task automatic test_random();
    logic r;
    logic e;
    for (int k = 0; k < 400; k++) begin
      r = ($urandom_range(0, 19) == 0);
      e = ($urandom_range(0, 9) < 7);
      step(8'($urandom), r, e);
      n_tests++;
      if (uo_out !== exp_out() || uio_oe !== 8'h00 || uio_out !== 8'h00) begin
        n_fail++;
        $display("FAIL random_%0d: got %h/%h/%h expected %h/00/00", k, uo_out, uio_oe, uio_out, exp_out());
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m0      = 8'h00;
    m1      = 8'h00;
    rst     = 1'b1;
    ena     = 1'b0;
    ui_in   = 8'h00;
    uio_in  = 8'h00;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_exhaustive();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
